// File: rtl/qnna_pkg.sv
`default_nettype none
// =====================================================================
// qnna_pkg: shared tile geometry defaults, scheduler states, clip helper
// Rev 1.0
// =====================================================================
package qnna_pkg;

  localparam int unsigned TILE_M_DEF = 4;
  localparam int unsigned TILE_N_DEF = 4;
  localparam int unsigned DIM_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FIN   = 2'd3
  } state_e;

  // Callers zero-extend into 32 bits, so the remainder never wraps for DIM_W <= 31.
  function automatic logic [31:0] clip_min(input logic [31:0] lim, input logic [31:0] rem);
    return (rem < lim) ? rem : lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qnna_tile_iter.sv
`default_nettype none
// =====================================================================
// qnna_tile_iter: row-major tile offset walker with edge clip and last-tile detect
// Rev 1.0
// =====================================================================
module qnna_tile_iter
  import qnna_pkg::*;
#(
  parameter int unsigned TILE_M = TILE_M_DEF,
  parameter int unsigned TILE_N = TILE_N_DEF,
  parameter int unsigned DIM_W  = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init_i,
  input  logic             step_i,
  input  logic [DIM_W-1:0] m_i,
  input  logic [DIM_W-1:0] n_i,
  output logic [DIM_W-1:0] row_o,
  output logic [DIM_W-1:0] col_o,
  output logic [DIM_W-1:0] dim_m_o,
  output logic [DIM_W-1:0] dim_n_o,
  output logic             last_o
);

  localparam int unsigned XW = DIM_W + 1;

  logic [DIM_W-1:0] row_q, row_d;
  logic [DIM_W-1:0] col_q, col_d;
  logic [DIM_W:0]   row_end;
  logic [DIM_W:0]   col_end;
  logic             row_last;
  logic             col_last;

  // One extra bit keeps the end-of-tile sums exact when M or N sit near 2^DIM_W-1.
  assign row_end  = {1'b0, row_q} + XW'(TILE_M);
  assign col_end  = {1'b0, col_q} + XW'(TILE_N);
  assign row_last = (row_end >= {1'b0, m_i});
  assign col_last = (col_end >= {1'b0, n_i});

  assign row_o   = row_q;
  assign col_o   = col_q;
  assign last_o  = row_last && col_last;
  assign dim_m_o = DIM_W'(clip_min(TILE_M, 32'(m_i) - 32'(row_q)));
  assign dim_n_o = DIM_W'(clip_min(TILE_N, 32'(n_i) - 32'(col_q)));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (init_i) begin
      row_d = '0;
      col_d = '0;
    end else if (step_i) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_end[DIM_W-1:0];
      end else begin
        col_d = col_end[DIM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/qnna_tile_scheduler.sv
`default_nettype none
// =====================================================================
// qnna_tile_scheduler: splits one GEMM job into MAC-array tile runs
// Rev 1.0
// =====================================================================
module qnna_tile_scheduler
  import qnna_pkg::*;
#(
  parameter int unsigned TILE_M = TILE_M_DEF,
  parameter int unsigned TILE_N = TILE_N_DEF,
  parameter int unsigned DIM_W  = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             job_valid_i,
  output logic             job_ready_o,
  input  logic [DIM_W-1:0] job_m_i,
  input  logic [DIM_W-1:0] job_n_i,
  input  logic [DIM_W-1:0] job_k_i,
  input  logic             job_relu_i,
  input  logic             abort_i,
  output logic             mac_start_o,
  input  logic             mac_done_i,
  output logic [DIM_W-1:0] mac_dim_m_o,
  output logic [DIM_W-1:0] mac_dim_n_o,
  output logic [DIM_W-1:0] mac_dim_k_o,
  output logic             mac_relu_en_o,
  output logic [DIM_W-1:0] tile_row_o,
  output logic [DIM_W-1:0] tile_col_o,
  output logic             busy_o,
  output logic [31:0]      tiles_done_o,
  output logic             job_done_o,
  output logic             job_err_o,
  output logic             job_aborted_o
);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] m_q, m_d;
  logic [DIM_W-1:0] n_q, n_d;
  logic [DIM_W-1:0] k_q, k_d;
  logic             relu_q, relu_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;
  logic             abort_pend_q, abort_pend_d;
  logic [31:0]      tiles_q, tiles_d;
  logic             iter_init;
  logic             iter_step;
  logic             iter_last;
  logic             job_zero;

  qnna_tile_iter #(
    .TILE_M (TILE_M),
    .TILE_N (TILE_N),
    .DIM_W  (DIM_W)
  ) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .init_i  (iter_init),
    .step_i  (iter_step),
    .m_i     (m_q),
    .n_i     (n_q),
    .row_o   (tile_row_o),
    .col_o   (tile_col_o),
    .dim_m_o (mac_dim_m_o),
    .dim_n_o (mac_dim_n_o),
    .last_o  (iter_last)
  );

  assign job_zero = (job_m_i == '0) || (job_n_i == '0) || (job_k_i == '0);

  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    n_d          = n_q;
    k_d          = k_q;
    relu_d       = relu_q;
    err_d        = err_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    tiles_d      = tiles_q;
    iter_init    = 1'b0;
    iter_step    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (job_valid_i) begin
          m_d          = job_m_i;
          n_d          = job_n_i;
          k_d          = job_k_i;
          relu_d       = job_relu_i;
          err_d        = job_zero;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          tiles_d      = '0;
          iter_init    = 1'b1;
          state_d      = job_zero ? ST_FIN : ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (abort_i) abort_pend_d = 1'b1;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (abort_i) abort_pend_d = 1'b1;
        // done is only trusted here: the array clears it on the start pulse of ISSUE.
        if (mac_done_i) begin
          if (tiles_q != '1) tiles_d = tiles_q + 32'd1;
          if (iter_last) begin
            state_d = ST_FIN;
          end else if (abort_pend_q || abort_i) begin
            aborted_d = 1'b1;
            state_d   = ST_FIN;
          end else begin
            iter_step = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end

      ST_FIN: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      m_q          <= '0;
      n_q          <= '0;
      k_q          <= '0;
      relu_q       <= 1'b0;
      err_q        <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      tiles_q      <= '0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      n_q          <= n_d;
      k_q          <= k_d;
      relu_q       <= relu_d;
      err_q        <= err_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      tiles_q      <= tiles_d;
    end
  end

  assign job_ready_o   = (state_q == ST_IDLE);
  assign busy_o        = (state_q != ST_IDLE);
  assign mac_start_o   = (state_q == ST_ISSUE);
  assign job_done_o    = (state_q == ST_FIN);
  assign job_err_o     = job_done_o && err_q;
  assign job_aborted_o = job_done_o && aborted_q;
  assign mac_dim_k_o   = k_q;
  assign mac_relu_en_o = relu_q;
  assign tiles_done_o  = tiles_q;

endmodule
`default_nettype wire

// File: tb/tb_qnna_tile_scheduler.sv
`default_nettype none
// Directed bench for qnna_tile_scheduler: job vector table plus hand-written corner sequences.
module tb_qnna_tile_scheduler;

  typedef struct packed {
    logic [15:0] r, c, dm, dn, k;
    logic        relu;
  } tile_t;

  typedef struct {
    logic [15:0] m, n, k;
    logic        relu;
    int          abort_tile;
    int          abort_mode;
    int          exp_tiles;
    logic        exp_err;
    logic        exp_abt;
    tile_t [3:0] tl;
  } vec_t;

  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        job_valid_i = 1'b0;
  logic        job_ready_o;
  logic [15:0] job_m_i = '0, job_n_i = '0, job_k_i = '0;
  logic        job_relu_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        mac_start_o;
  logic        mac_done_i;
  logic [15:0] mac_dim_m_o, mac_dim_n_o, mac_dim_k_o;
  logic        mac_relu_en_o;
  logic [15:0] tile_row_o, tile_col_o;
  logic        busy_o;
  logic [31:0] tiles_done_o;
  logic        job_done_o, job_err_o, job_aborted_o;

  always #5 clk = ~clk;

  qnna_tile_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .job_valid_i   (job_valid_i),
    .job_ready_o   (job_ready_o),
    .job_m_i       (job_m_i),
    .job_n_i       (job_n_i),
    .job_k_i       (job_k_i),
    .job_relu_i    (job_relu_i),
    .abort_i       (abort_i),
    .mac_start_o   (mac_start_o),
    .mac_done_i    (mac_done_i),
    .mac_dim_m_o   (mac_dim_m_o),
    .mac_dim_n_o   (mac_dim_n_o),
    .mac_dim_k_o   (mac_dim_k_o),
    .mac_relu_en_o (mac_relu_en_o),
    .tile_row_o    (tile_row_o),
    .tile_col_o    (tile_col_o),
    .busy_o        (busy_o),
    .tiles_done_o  (tiles_done_o),
    .job_done_o    (job_done_o),
    .job_err_o     (job_err_o),
    .job_aborted_o (job_aborted_o)
  );

  // MAC array model: done rises D edges after the start edge and drops on the next start.
  int unsigned mcnt;
  logic        mdone;
  logic        fast_d = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdone <= 1'b0;
      mcnt  <= 0;
    end else if (mac_start_o) begin
      mdone <= 1'b0;
      mcnt  <= fast_d ? 1 : $urandom_range(20, 1);
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mdone <= 1'b1;
    end
  end
  assign mac_done_i = mdone;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic tile_t mk(input int r, c, dm, dn, k, input bit relu);
    return {16'(r), 16'(c), 16'(dm), 16'(dn), 16'(k), relu};
  endfunction

  function automatic vec_t mv(input int m, n, k, input bit relu, input int at, am, et,
                              input bit err, abt);
    vec_t v;
    v.m = 16'(m); v.n = 16'(n); v.k = 16'(k); v.relu = relu;
    v.abort_tile = at; v.abort_mode = am; v.exp_tiles = et;
    v.exp_err = err; v.exp_abt = abt; v.tl = '0;
    return v;
  endfunction

  function automatic logic [127:0] outs();
    return 128'({job_ready_o, busy_o, mac_start_o, job_done_o, job_err_o, job_aborted_o,
                 mac_relu_en_o, tiles_done_o, tile_row_o, tile_col_o,
                 mac_dim_m_o, mac_dim_n_o, mac_dim_k_o});
  endfunction

  // Results captured by watch_job
  int          w_starts, w_hold_bad, w_order_bad, w_ready_bad;
  logic        w_first_evt, w_prev_done, w_done_seen, w_err, w_abt;
  logic [31:0] w_tiles, w_tiles_first;
  tile_t       w_first [4];
  tile_t       w_last;

  // Call at a negedge; drives job fields and returns at the negedge after the accept edge.
  task automatic start_job(input int m, n, k, input bit relu, output logic ok);
    int t;
    job_m_i = 16'(m); job_n_i = 16'(n); job_k_i = 16'(k); job_relu_i = relu;
    job_valid_i = 1'b1;
    t = 0;
    while (!job_ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    ok = job_ready_o;
    @(posedge clk);
    @(negedge clk);
    job_valid_i = 1'b0;
  endtask

  // abort_mode 1: pulse in the first WAIT cycle of tile abort_tile; 2: coincide with its done.
  task automatic watch_job(input int abort_tile, input int abort_mode, input int bound);
    int    cyc;
    logic  prev_done;
    logic  abort_sent;
    tile_t cur;
    w_starts = 0; w_hold_bad = 0; w_order_bad = 0; w_ready_bad = 0;
    w_first_evt = 1'b0; w_prev_done = 1'b0; w_done_seen = 1'b0;
    w_err = 1'b0; w_abt = 1'b0; w_tiles = '0; w_tiles_first = '1; w_last = '0;
    prev_done = 1'b0; abort_sent = 1'b0; cyc = 0;
    while (!w_done_seen && cyc < bound) begin
      abort_i = 1'b0;
      cur = {tile_row_o, tile_col_o, mac_dim_m_o, mac_dim_n_o, mac_dim_k_o, mac_relu_en_o};
      if (job_ready_o || !busy_o) w_ready_bad++;
      if (mac_start_o) begin
        if (cyc == 0) w_first_evt = 1'b1;
        if (w_starts == 0) w_tiles_first = tiles_done_o;
        if (w_starts > 0 &&
            !((cur.r == w_last.r && cur.c > w_last.c) || (cur.c == 16'd0 && cur.r > w_last.r)))
          w_order_bad++;
        if (w_starts < 4) w_first[w_starts] = cur;
        w_last = cur;
        w_starts++;
      end else if (job_done_o) begin
        if (cyc == 0) w_first_evt = 1'b1;
        w_err = job_err_o; w_abt = job_aborted_o; w_tiles = tiles_done_o;
        w_prev_done = prev_done;
        w_done_seen = 1'b1;
      end else begin
        if (cur != w_last) w_hold_bad++;
        if (abort_tile != 0 && !abort_sent && w_starts == abort_tile &&
            (abort_mode == 1 || mac_done_i)) begin
          abort_i = 1'b1;
          abort_sent = 1'b1;
        end
      end
      prev_done = mac_done_i;
      if (!w_done_seen) begin
        @(negedge clk);
        cyc++;
      end
    end
    abort_i = 1'b0;
  endtask

  vec_t vecs [NV];

  initial begin
    logic         ok;
    int           cnt, t;
    logic [127:0] exp_rst;

    vecs[0] = mv(8, 8, 3, 0, 0, 0, 4, 0, 0);
    vecs[0].tl[0] = mk(0, 0, 4, 4, 3, 0); vecs[0].tl[1] = mk(0, 4, 4, 4, 3, 0);
    vecs[0].tl[2] = mk(4, 0, 4, 4, 3, 0); vecs[0].tl[3] = mk(4, 4, 4, 4, 3, 0);
    vecs[1] = mv(5, 6, 2, 1, 0, 0, 4, 0, 0);
    vecs[1].tl[0] = mk(0, 0, 4, 4, 2, 1); vecs[1].tl[1] = mk(0, 4, 4, 2, 2, 1);
    vecs[1].tl[2] = mk(4, 0, 1, 4, 2, 1); vecs[1].tl[3] = mk(4, 4, 1, 2, 2, 1);
    vecs[2] = mv(0, 4, 4, 0, 0, 0, 0, 1, 0);
    vecs[3] = mv(8, 8, 1, 0, 2, 1, 2, 0, 1);
    vecs[3].tl[0] = mk(0, 0, 4, 4, 1, 0); vecs[3].tl[1] = mk(0, 4, 4, 4, 1, 0);
    vecs[4] = mv(4, 4, 1, 1, 1, 2, 1, 0, 0);
    vecs[4].tl[0] = mk(0, 0, 4, 4, 1, 1);
    vecs[5] = mv(8, 4, 7, 0, 1, 2, 1, 0, 1);
    vecs[5].tl[0] = mk(0, 0, 4, 4, 7, 0);
    vecs[6] = mv(3, 9, 5, 0, 0, 0, 3, 0, 0);
    vecs[6].tl[0] = mk(0, 0, 3, 4, 5, 0); vecs[6].tl[1] = mk(0, 4, 3, 4, 5, 0);
    vecs[6].tl[2] = mk(0, 8, 3, 1, 5, 0);
    vecs[7] = mv(4, 4, 0, 1, 0, 0, 0, 1, 0);

    exp_rst = '0;
    exp_rst[118] = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), exp_rst);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      start_job(vecs[i].m, vecs[i].n, vecs[i].k, vecs[i].relu, ok);
      check($sformatf("v%0d_accept", i), 128'(ok), 128'(1));
      watch_job(vecs[i].abort_tile, vecs[i].abort_mode, 2000);
      check($sformatf("v%0d_done_seen", i), 128'(w_done_seen), 128'(1));
      check($sformatf("v%0d_first_latency", i), 128'(w_first_evt), 128'(1));
      check($sformatf("v%0d_starts", i), 128'(w_starts), 128'(vecs[i].exp_tiles));
      for (int j = 0; j < vecs[i].exp_tiles && j < 4; j++)
        check($sformatf("v%0d_tile%0d", i, j), 128'(w_first[j]), 128'(vecs[i].tl[j]));
      check($sformatf("v%0d_tiles_done", i), 128'(w_tiles), 128'(vecs[i].exp_tiles));
      check($sformatf("v%0d_err", i), 128'(w_err), 128'(vecs[i].exp_err));
      check($sformatf("v%0d_aborted", i), 128'(w_abt), 128'(vecs[i].exp_abt));
      check($sformatf("v%0d_ready_busy", i), 128'(w_ready_bad), 128'(0));
      check($sformatf("v%0d_hold", i), 128'(w_hold_bad), 128'(0));
      if (!vecs[i].exp_err)
        check($sformatf("v%0d_done_latency", i), 128'(w_prev_done), 128'(1));
      @(negedge clk);
      check($sformatf("v%0d_after_done", i),
            128'({job_done_o, job_err_o, job_aborted_o, job_ready_o, busy_o, mac_start_o}),
            128'(6'b000100));
    end

    // Second job held on the request lines for the whole first job.
    start_job(8, 8, 3, 0, ok);
    check("b2b_accept1", 128'(ok), 128'(1));
    job_m_i = 16'd4; job_n_i = 16'd4; job_k_i = 16'd1; job_relu_i = 1'b0;
    job_valid_i = 1'b1;
    watch_job(0, 0, 2000);
    check("b2b_job1_starts", 128'(w_starts), 128'(4));
    check("b2b_job1_k_latched", 128'(w_first[3]), 128'(mk(4, 4, 4, 4, 3, 0)));
    check("b2b_job1_ready_low", 128'(w_ready_bad), 128'(0));
    @(negedge clk);
    check("b2b_idle_ready", 128'(job_ready_o), 128'(1));
    @(posedge clk);
    @(negedge clk);
    job_valid_i = 1'b0;
    watch_job(0, 0, 2000);
    check("b2b_job2_latency", 128'(w_first_evt), 128'(1));
    check("b2b_job2_cleared", 128'(w_tiles_first), 128'(0));
    check("b2b_job2_tile", 128'(w_first[0]), 128'(mk(0, 0, 4, 4, 1, 0)));
    check("b2b_job2_tiles_done", 128'(w_tiles), 128'(1));
    @(negedge clk);

    // Asynchronous reset landing between edges while a tile is in flight.
    start_job(8, 8, 5, 1, ok);
    cnt = 0; t = 0;
    while (cnt < 2 && t < 500) begin
      if (mac_start_o) cnt++;
      @(negedge clk);
      t++;
    end
    check("rst_reach_tile2", 128'(cnt), 128'(2));
    #2 rst_n = 1'b0;
    #1 check("rst_async_outputs", outs(), exp_rst);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (job_done_o || mac_start_o) cnt++;
    end
    check("rst_quiet_after", 128'(cnt), 128'(0));
    check("rst_idle_outputs", outs(), exp_rst);

    // Near-max M: rows must clip to 3 on the last tile without the offset wrapping.
    fast_d = 1'b1;
    start_job(65535, 3, 1, 0, ok);
    check("big_accept", 128'(ok), 128'(1));
    watch_job(0, 0, 60000);
    check("big_done_seen", 128'(w_done_seen), 128'(1));
    check("big_starts", 128'(w_starts), 128'(16384));
    check("big_first_tile", 128'(w_first[0]), 128'(mk(0, 0, 4, 3, 1, 0)));
    check("big_last_tile", 128'(w_last), 128'(mk(65532, 0, 3, 3, 1, 0)));
    check("big_order", 128'(w_order_bad), 128'(0));
    check("big_tiles_done", 128'(w_tiles), 128'(16384));
    fast_d = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
